gf_mul_seq_cxu: RTL and testbench

Multi-cycle, constant-time GF(2^8) arithmetic custom-extension unit for the AES software path, on the same CXU cmd/rsp handshake the core already drives. It generalises the combinational byte multiplier in three ways: parametrised lane count, a bit-serial or digit-serial multiply engine, and sequential exponentiation and inversion built from that engine (square-and-multiply). Latency depends only on function_id and parameters, never on operand values.

---
 rtl/gf_mul_seq_cxu.sv | 207 ++++++++++++++++++++
 tb/tb_gf_mul_seq_cxu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gf_mul_seq_cxu.sv
// gf_mul_seq_cxu: multi-cycle, constant-time GF(2^8) unit for the AES path.
// Byte-lane multiply, exponentiation and inversion on one shared
// shift-and-add engine; latency depends only on function_id and parameters.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
// (cmd_ready is high only in IDLE); a response transfers on a rising edge where
// rsp_valid && rsp_ready. rsp_valid and rsp_payload_outputs_0 hold steady until
// that edge, and no command is accepted on the response edge itself.
module gf_mul_seq_cxu #(
   parameter int         LANES          = 4,
   parameter int         BITS_PER_CYCLE = 1,
   parameter logic [8:0] RED_POLY       = 9'h11B
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0
);

   localparam int          P         = 8 / BITS_PER_CYCLE;
   localparam logic [2:0]  CNT_LAST  = 3'(P - 1);
   localparam logic [31:0] LANE_MASK = (LANES >= 4) ? 32'hFFFF_FFFF :
                                       (LANES == 2) ? 32'h0000_FFFF : 32'h0000_00FF;

   typedef enum logic [2:0] {IDLE, MUL, POW_SQ, POW_MUL, DONE} state_t;

   // state is the observable FSM state for checkers
   state_t      state, state_n;
   logic        vec_q, vec_n;
   logic [31:0] a_q, a_n;          // latched operand A (pow base)
   logic [31:0] e_q, e_n;          // latched exponent bytes
   logic [31:0] mcand, mcand_n;    // multiplicand; doubles as pow accumulator
   logic [31:0] mplier, mplier_n;  // multiplier, consumed MSB first
   logic [31:0] prod, prod_n;      // running partial product
   logic [2:0]  cnt, cnt_n;        // digit counter within one pass
   logic [2:0]  bit_idx, bit_idx_n;// exponent bit being processed
   logic        rsp_valid_n;
   logic [31:0] rsp_data_n;

   logic [31:0] step_prod, step_mplier, acc_new, out_mask;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? RED_POLY[7:0] : 8'h00);
   endfunction

   // One digit: BITS_PER_CYCLE Horner steps with reduction after each shift
   function automatic logic [7:0] digit_step(input logic [7:0] p, input logic [7:0] a,
                                             input logic [7:0] m);
      logic [7:0] r;
      r = p;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r = xtime(r) ^ (m[7-i] ? a : 8'h00);
      end
      return r;
   endfunction

   assign cmd_ready = (state == IDLE);
   assign out_mask  = vec_q ? LANE_MASK : 32'h0000_00FF;

   // Per-lane datapath: next digit of each product and the pow select
   always_comb begin
      step_prod   = '0;
      step_mplier = '0;
      acc_new     = '0;
      for (int k = 0; k < 4; k++) begin
         step_prod[8*k +: 8]   = digit_step(prod[8*k +: 8], mcand[8*k +: 8], mplier[8*k +: 8]);
         step_mplier[8*k +: 8] = mplier[8*k +: 8] << BITS_PER_CYCLE;
         acc_new[8*k +: 8]     = e_q[8*k + int'(bit_idx)] ? step_prod[8*k +: 8]
                                                          : mcand[8*k +: 8];
      end
   end

   // FSM next-state and register next values
   always_comb begin
      state_n     = state;
      vec_n       = vec_q;
      a_n         = a_q;
      e_n         = e_q;
      mcand_n     = mcand;
      mplier_n    = mplier;
      prod_n      = prod;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      rsp_valid_n = rsp_valid;
      rsp_data_n  = rsp_payload_outputs_0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               vec_n  = cmd_payload_function_id[0];
               cnt_n  = '0;
               prod_n = '0;
               case (cmd_payload_function_id)
                  3'd0, 3'd1: begin
                     mcand_n  = cmd_payload_inputs_0;
                     mplier_n = cmd_payload_inputs_1;
                     state_n  = MUL;
                  end
                  3'd2, 3'd3, 3'd4, 3'd5: begin
                     a_n       = cmd_payload_inputs_0;
                     e_n       = cmd_payload_function_id[2] ? 32'hFEFE_FEFE : cmd_payload_inputs_1;
                     mcand_n   = 32'h0101_0101;
                     mplier_n  = 32'h0101_0101;
                     bit_idx_n = 3'd7;
                     state_n   = POW_SQ;
                  end
                  default: begin
                     rsp_data_n = '0;
                     state_n    = DONE;
                  end
               endcase
            end
         end
         MUL: begin
            prod_n   = step_prod;
            mplier_n = step_mplier;
            cnt_n    = cnt + 3'd1;
            if (cnt == CNT_LAST) begin
               cnt_n       = '0;
               rsp_data_n  = step_prod & out_mask;
               rsp_valid_n = 1'b1;
               state_n     = DONE;
            end
         end
         POW_SQ: begin
            prod_n   = step_prod;
            mplier_n = step_mplier;
            cnt_n    = cnt + 3'd1;
            if (cnt == CNT_LAST) begin
               cnt_n    = '0;
               prod_n   = '0;
               mcand_n  = step_prod;
               mplier_n = a_q;
               state_n  = POW_MUL;
            end
         end
         POW_MUL: begin
            prod_n   = step_prod;
            mplier_n = step_mplier;
            cnt_n    = cnt + 3'd1;
            if (cnt == CNT_LAST) begin
               cnt_n    = '0;
               prod_n   = '0;
               mcand_n  = acc_new;
               mplier_n = acc_new;
               if (bit_idx == 3'd0) begin
                  rsp_data_n  = acc_new & out_mask;
                  rsp_valid_n = 1'b1;
                  state_n     = DONE;
               end else begin
                  bit_idx_n = bit_idx - 3'd1;
                  state_n   = POW_SQ;
               end
            end
         end
         DONE: begin
            // illegal functions arrive here with rsp_valid low; raise it one edge later
            if (!rsp_valid) begin
               rsp_valid_n = 1'b1;
            end else if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Datapath and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vec_q                 <= 1'b0;
         a_q                   <= '0;
         e_q                   <= '0;
         mcand                 <= '0;
         mplier                <= '0;
         prod                  <= '0;
         cnt                   <= '0;
         bit_idx               <= '0;
         rsp_valid             <= 1'b0;
         rsp_payload_outputs_0 <= '0;
      end else begin
         vec_q                 <= vec_n;
         a_q                   <= a_n;
         e_q                   <= e_n;
         mcand                 <= mcand_n;
         mplier                <= mplier_n;
         prod                  <= prod_n;
         cnt                   <= cnt_n;
         bit_idx               <= bit_idx_n;
         rsp_valid             <= rsp_valid_n;
         rsp_payload_outputs_0 <= rsp_data_n;
      end
   end

endmodule

// File: tb/tb_gf_mul_seq_cxu.sv
// tb_gf_mul_seq_cxu: directed bench for gf_mul_seq_cxu. Instance u_dut uses
// defaults (LANES=4, BITS_PER_CYCLE=1); u_dut2 uses LANES=2, BITS_PER_CYCLE=8.
module tb_gf_mul_seq_cxu;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic [1:0]  cv;
   logic [1:0]  rr;
   logic [2:0]  fn;
   logic [31:0] in0, in1;
   logic        cr1, rv1, cr2, rv2;
   logic [31:0] out1, out2;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   logic [31:0] exp_q[$];

   gf_mul_seq_cxu u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cv[0]), .cmd_ready(cr1),
      .cmd_payload_function_id(fn),
      .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
      .rsp_valid(rv1), .rsp_ready(rr[0]), .rsp_payload_outputs_0(out1)
   );

   gf_mul_seq_cxu #(.LANES(2), .BITS_PER_CYCLE(8), .RED_POLY(9'h11B)) u_dut2 (
      .clk(clk), .reset(reset),
      .cmd_valid(cv[1]), .cmd_ready(cr2),
      .cmd_payload_function_id(fn),
      .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
      .rsp_valid(rv2), .rsp_ready(rr[1]), .rsp_payload_outputs_0(out2)
   );

   function automatic logic g_cr(input int sel);
      return (sel != 0) ? cr2 : cr1;
   endfunction
   function automatic logic g_rv(input int sel);
      return (sel != 0) ? rv2 : rv1;
   endfunction
   function automatic logic [31:0] g_out(input int sel);
      return (sel != 0) ? out2 : out1;
   endfunction

   // Independent reference: LSB-first peasant multiply, poly 0x11B
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   // ---------------- scoreboard compare ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Issue one command, wait for the response, check latency/data, retire it.
   // With hold set, scribble on the cmd bus while busy and stall rsp_ready 20 cycles.
   task automatic txn(input int sel, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                      input string tag, input bit hold);
      int n;
      logic [31:0] held;
      logic stable;
      exp_q.push_back(exp);
      @(negedge clk);
      n = 0;
      while (!g_cr(sel) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_cmd_ready"}, 32'(g_cr(sel)), 32'd1);
      fn = f; in0 = a; in1 = b;
      cv[sel] = 1'b1;
      @(posedge clk);
      #1;
      cv[sel] = 1'b0;
      if (hold) begin
         fn = 3'd7; in0 = $urandom; in1 = $urandom;
         cv[sel] = 1'b1;
      end
      n = 0;
      while (!g_rv(sel) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      cv = 2'b00;
      check({tag, "_latency"}, 32'(n), 32'(exp_lat));
      check({tag, "_data"}, g_out(sel), exp_q.pop_front());
      if (hold) begin
         held = g_out(sel);
         stable = 1'b1;
         repeat (20) begin
            @(posedge clk);
            #1;
            if (!g_rv(sel) || g_out(sel) !== held || g_cr(sel)) stable = 1'b0;
         end
         check({tag, "_stall_stable"}, 32'(stable), 32'd1);
      end
      @(negedge clk);
      rr[sel] = 1'b1;
      @(posedge clk);
      #1;
      rr[sel] = 1'b0;
      check({tag, "_rsp_cleared"}, {30'd0, g_rv(sel), g_cr(sel)}, 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] ra, rb;
      cv = 2'b00; rr = 2'b00; fn = 3'd0; in0 = '0; in1 = '0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #10;
      check("reset_rsp_valid", {31'd0, rv1}, 32'd0);
      check("reset_data", out1, 32'd0);
      check("reset_cmd_ready", {31'd0, cr1}, 32'd1);
      @(negedge clk);
      reset = 1'b1;

      // multiply, scalar and vector
      txn(0, 3'd0, 32'h0000_0057, 32'h0000_0083, 32'h0000_00C1, 8, "mul_57_83", 1'b0);
      txn(0, 3'd0, 32'h0000_0057, 32'h0000_0013, 32'h0000_00FE, 8, "mul_57_13", 1'b0);
      txn(0, 3'd0, 32'hAABB_CC57, 32'h1122_3383, 32'h0000_00C1, 8, "mul_zext", 1'b0);
      txn(0, 3'd1, 32'h0102_0357, 32'h8080_8313, 32'h801B_9EFE, 8, "vmul", 1'b0);

      // power and inverse
      txn(0, 3'd2, 32'h0000_0002, 32'h0000_0008, 32'h0000_001B, 128, "pow_02_08", 1'b0);
      txn(0, 3'd2, 32'h0000_0003, 32'h0000_00FF, 32'h0000_0001, 128, "pow_03_ff", 1'b0);
      txn(0, 3'd2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 128, "pow_00_00", 1'b0);
      txn(0, 3'd2, 32'hFFFF_FF02, 32'h1234_5608, 32'h0000_001B, 128, "pow_zext", 1'b0);
      txn(0, 3'd4, 32'h0000_0053, 32'h1234_5678, 32'h0000_00CA, 128, "inv_53", 1'b0);
      txn(0, 3'd4, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 128, "inv_00", 1'b0);
      txn(0, 3'd3, 32'h5300_0302, 32'hFE00_FF08, 32'hCA01_011B, 128, "vpow", 1'b0);
      txn(0, 3'd5, 32'h5300_0302, 32'h0000_0000, 32'hCA00_F68D, 128, "vinv", 1'b0);

      // illegal functions
      txn(0, 3'd7, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1, "illegal_7", 1'b0);
      txn(0, 3'd6, 32'h0000_0057, 32'h0000_0083, 32'h0000_0000, 1, "illegal_6", 1'b0);

      // backpressure with bus scribbling while busy
      txn(0, 3'd2, 32'h0000_0002, 32'h0000_0008, 32'h0000_001B, 128, "stall_pow", 1'b1);

      // reset in the middle of a vector inverse
      @(negedge clk);
      fn = 3'd5; in0 = 32'h5300_0302; in1 = '0;
      cv[0] = 1'b1;
      @(posedge clk);
      #1;
      cv[0] = 1'b0;
      check("midrst_busy", {31'd0, cr1}, 32'd0);
      repeat (39) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("midrst_rsp_valid", {31'd0, rv1}, 32'd0);
      check("midrst_data", out1, 32'd0);
      check("midrst_cmd_ready", {31'd0, cr1}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      txn(0, 3'd0, 32'h0000_0057, 32'h0000_0083, 32'h0000_00C1, 8, "post_rst_mul", 1'b0);

      // two-lane, byte-per-cycle instance
      txn(1, 3'd0, 32'h0000_0057, 32'h0000_0083, 32'h0000_00C1, 1, "d2_mul", 1'b0);
      txn(1, 3'd1, 32'h0102_0357, 32'h8080_8313, 32'h0000_9EFE, 1, "d2_vmul", 1'b0);
      txn(1, 3'd3, 32'h5300_0302, 32'hFE00_FF08, 32'h0000_011B, 16, "d2_vpow", 1'b0);
      txn(1, 3'd7, 32'h0000_0057, 32'h0000_0083, 32'h0000_0000, 1, "d2_illegal", 1'b0);

      // random scalar multiply sweep against the reference
      for (int i = 0; i < 150; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         txn(0, 3'd0, {24'd0, ra}, {24'd0, rb}, {24'd0, ref_mul(ra, rb)}, 8, "rand_mul", 1'b0);
      end

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
